// File: rtl/rf_arb_pkg.sv
// Shared definitions for the decode-stage register-file write port.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: address/data widths of the 32x18 register file and the write-port
// arbiter state encoding, kept as plain constants so legacy blocks can reuse them.
package rf_arb_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 18;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_INIT  = 2'd0;  // clearing the register file after reset
    localparam arb_state_t ST_RUN   = 2'd1;  // writeback first, host when the port is idle
    localparam arb_state_t ST_DRAIN = 2'd2;  // pipeline held, in-flight writebacks emptying
    localparam arb_state_t ST_HOST  = 2'd3;  // pipeline held, host owns the next free cycle

endpackage

// File: rtl/rf_init_sequencer.sv
// Post-reset clear sequencer: writes zero to registers 0..NUM_REGS-1, one per cycle.
// Latency: clear write for idx is combinational from idx; done rises the cycle after the last write.
// Backpressure: none; the sequencer owns the write port outright until done.
// Ports: clk, rst (async active-low); clr_we/clr_addr = clear write request,
// clr_last = this cycle writes the final register, done = sequence complete.
module rf_init_sequencer
    import rf_arb_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 clr_we,
    output logic [RF_ADDR_W-1:0] clr_addr,
    output logic                 clr_last,
    output logic                 done
);

    localparam logic [RF_ADDR_W-1:0] LAST_IDX = RF_ADDR_W'(NUM_REGS - 1);

    logic [RF_ADDR_W-1:0] idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx  <= '0;
            done <= 1'b0;
        end else if (!done) begin
            if (idx == LAST_IDX) begin
                idx  <= '0;
                done <= 1'b1;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign clr_we   = !done;
    assign clr_addr = idx;
    assign clr_last = !done && (idx == LAST_IDX);

endmodule

// File: rtl/rf_write_port_arbiter.sv
// Single write port of the decode register file: post-reset clear, then writeback vs host loader.
// Latency: all outputs combinational from state/counters/inputs; the write lands on the next clk edge.
// Backpressure: host_req is held until host_gnt; a starved host raises hold to stall the pipeline.
// Ports: clk, rst (async active-low); wb_* = pipeline writeback; host_* = loader request/grant;
// rf_* = register file WE3/A3/WD3; hold = stall request; init_done = clear finished.
// Optional macro RF_HOST_WCOUNT_EN adds host_wcount, a saturating count of host grants.
module rf_write_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int DATA_W     = RF_DATA_W,
    parameter int DRAIN_CYC  = 3,
    parameter int STARVE_LIM = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_we,
    input  logic [RF_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 host_req,
    input  logic [RF_ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0]    host_data,
    output logic                 host_gnt,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 hold,
`ifdef RF_HOST_WCOUNT_EN
    output logic [15:0]          host_wcount,
`endif
    output logic                 init_done
);

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIM - 1);
    localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_CYC - 1);

    arb_state_t    state, state_nxt;
    logic [SW-1:0] starve, starve_nxt;
    logic [DW-1:0] drain, drain_nxt;

    logic                 clr_we;
    logic [RF_ADDR_W-1:0] clr_addr;
    logic                 clr_last;
    logic                 clr_done;

    rf_init_sequencer #(
        .NUM_REGS (NUM_REGS)
    ) u_init (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_last (clr_last),
        .done     (clr_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_INIT;
            starve <= '0;
            drain  <= '0;
        end else begin
            state  <= state_nxt;
            starve <= starve_nxt;
            drain  <= drain_nxt;
        end
    end

    always_comb begin
        rf_we      = 1'b0;
        rf_addr    = '0;
        rf_wdata   = '0;
        host_gnt   = 1'b0;
        state_nxt  = state;
        starve_nxt = starve;
        drain_nxt  = drain;

        // Writeback wins the port in every state except INIT.
        if (state != ST_INIT && wb_we) begin
            rf_we    = 1'b1;
            rf_addr  = wb_addr;
            rf_wdata = wb_data;
        end

        case (state)
            ST_INIT: begin
                rf_we      = clr_we;
                rf_addr    = clr_addr;
                rf_wdata   = '0;
                starve_nxt = '0;
                drain_nxt  = '0;
                if (clr_last) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (wb_we) begin
                    if (host_req) begin
                        // Jump on the edge that completes the STARVE_LIM-th blocked
                        // cycle so hold rises on the very next cycle.
                        if (starve >= STARVE_LAST) begin
                            state_nxt  = ST_DRAIN;
                            starve_nxt = '0;
                            drain_nxt  = '0;
                        end else begin
                            starve_nxt = starve + 1'b1;
                        end
                    end else begin
                        starve_nxt = '0;
                    end
                end else begin
                    starve_nxt = '0;
                    if (host_req) begin
                        rf_we    = 1'b1;
                        rf_addr  = host_addr;
                        rf_wdata = host_data;
                        host_gnt = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!host_req) begin
                    state_nxt = ST_RUN;
                end else if (drain == DRAIN_LAST) begin
                    state_nxt = ST_HOST;
                end else begin
                    drain_nxt = drain + 1'b1;
                end
            end
            ST_HOST: begin
                // A writeback here means the pipeline ignored hold; let it through
                // and keep the host waiting rather than lose pipeline state.
                if (!wb_we) begin
                    state_nxt  = ST_RUN;
                    starve_nxt = '0;
                    if (host_req) begin
                        rf_we    = 1'b1;
                        rf_addr  = host_addr;
                        rf_wdata = host_data;
                        host_gnt = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    assign hold      = (state != ST_RUN);
    assign init_done = clr_done;

`ifdef RF_HOST_WCOUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            host_wcount <= '0;
        end else if (host_gnt && host_wcount != 16'hFFFF) begin
            host_wcount <= host_wcount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_port_arbiter.sv
// Bench for rf_write_port_arbiter: directed scenarios then randomized traffic,
// every cycle compared against a reference model built on cycle/age counts.
module tb_rf_write_port_arbiter;

    localparam int NUM_REGS   = 32;
    localparam int DRAIN_CYC  = 3;
    localparam int STARVE_LIM = 8;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [17:0] wb_data;
    logic        host_req;
    logic [4:0]  host_addr;
    logic [17:0] host_data;
    logic        host_gnt;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [17:0] rf_wdata;
    logic        hold;
    logic        init_done;
`ifdef RF_HOST_WCOUNT_EN
    logic [15:0] host_wcount;
`endif

    rf_write_port_arbiter #(
        .NUM_REGS   (NUM_REGS),
        .DATA_W     (18),
        .DRAIN_CYC  (DRAIN_CYC),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .host_req  (host_req),
        .host_addr (host_addr),
        .host_data (host_data),
        .host_gnt  (host_gnt),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata),
        .hold      (hold),
`ifdef RF_HOST_WCOUNT_EN
        .host_wcount (host_wcount),
`endif
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: cycles of clearing done since reset, consecutive blocked
    // host cycles, and age of the current hold episode (-1 = no hold).
    int          m_cyc;
    int          m_blocked;
    int          m_age;
    int          m_gcnt;
    logic        last_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [17:0] wd,
                        input logic hr, input logic [4:0] ha, input logic [17:0] hd);
        logic        e_we, e_gnt, e_hold, e_done;
        logic [4:0]  e_addr;
        logic [17:0] e_data;
        @(negedge clk);
        rst = r; wb_we = we; wb_addr = wa; wb_data = wd;
        host_req = hr; host_addr = ha; host_data = hd;
        if (!r) begin
            m_cyc = 0; m_blocked = 0; m_age = -1; m_gcnt = 0;
        end
        #1;
        e_gnt = 1'b0;
        if (m_cyc < NUM_REGS) begin
            e_we = 1'b1; e_addr = m_cyc[4:0]; e_data = '0; e_hold = 1'b1; e_done = 1'b0;
        end else begin
            e_hold = (m_age >= 0);
            e_done = 1'b1;
            if (we) begin
                e_we = 1'b1; e_addr = wa; e_data = wd;
            end else if (hr && (m_age < 0 || m_age >= DRAIN_CYC)) begin
                e_we = 1'b1; e_addr = ha; e_data = hd; e_gnt = 1'b1;
            end else begin
                e_we = 1'b0; e_addr = '0; e_data = '0;
            end
        end
        chk("rf_we", 32'(rf_we), 32'(e_we));
        chk("rf_addr", 32'(rf_addr), 32'(e_addr));
        chk("rf_wdata", 32'(rf_wdata), 32'(e_data));
        chk("host_gnt", 32'(host_gnt), 32'(e_gnt));
        chk("hold", 32'(hold), 32'(e_hold));
        chk("init_done", 32'(init_done), 32'(e_done));
`ifdef RF_HOST_WCOUNT_EN
        chk("host_wcount", 32'(host_wcount), 32'(m_gcnt));
`endif
        last_gnt = e_gnt;
        @(posedge clk);
        if (r) begin
            if (m_cyc < NUM_REGS) begin
                m_cyc++;
            end else if (m_age < 0) begin
                if (we && hr) begin
                    m_blocked++;
                    if (m_blocked >= STARVE_LIM) begin
                        m_age = 0; m_blocked = 0;
                    end
                end else begin
                    m_blocked = 0;
                end
            end else if (!hr || e_gnt) begin
                m_age = -1; m_blocked = 0;
            end else if (m_age < 1000) begin
                m_age++;
            end
            if (e_gnt && m_gcnt < 65535) m_gcnt++;
        end
    endtask

    logic        pend;
    logic [4:0]  pa;
    logic [17:0] pd;
    logic        r_r, r_we;
    int          wb_pct;

    initial begin
        rst = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        host_req = 1'b0; host_addr = '0; host_data = '0;
        m_cyc = 0; m_blocked = 0; m_age = -1; m_gcnt = 0; last_gnt = 1'b0;

        // Reset, then idle clear sequence over all registers, then first RUN cycle.
        step(1'b0, 1'b0, 5'd0, 18'd0, 1'b0, 5'd0, 18'd0);
        step(1'b0, 1'b0, 5'd0, 18'd0, 1'b0, 5'd0, 18'd0);
        for (int i = 0; i < NUM_REGS; i++) step(1'b1, 1'b0, 5'd0, 18'd0, 1'b0, 5'd0, 18'd0);
        step(1'b1, 1'b0, 5'd0, 18'd0, 1'b0, 5'd0, 18'd0);
        chk("run_hold_low", 32'(hold), 32'd0);

        // Host write on an idle port is granted the same cycle.
        step(1'b1, 1'b0, 5'd0, 18'd0, 1'b1, 5'd5, 18'h2A5A);
        chk("host_direct_gnt", 32'(last_gnt), 32'd1);
        step(1'b1, 1'b0, 5'd0, 18'd0, 1'b1, 5'd7, 18'h00011);
        step(1'b1, 1'b0, 5'd0, 18'd0, 1'b1, 5'd31, 18'h3FFFF);
`ifdef RF_HOST_WCOUNT_EN
        step(1'b1, 1'b0, 5'd0, 18'd0, 1'b0, 5'd0, 18'd0);
        chk("wcount_three", 32'(host_wcount), 32'd3);
`endif

        // Starvation: 8 blocked cycles, hold on the 9th, two writebacks during
        // drain, then the host wins on the 4th hold cycle.
        for (int i = 0; i < STARVE_LIM; i++) step(1'b1, 1'b1, 5'd3, 18'(i + 100), 1'b1, 5'd9, 18'h1234);
        step(1'b1, 1'b1, 5'd3, 18'h0ABCD, 1'b1, 5'd9, 18'h1234);
        chk("hold_rise", 32'(hold), 32'd1);
        step(1'b1, 1'b1, 5'd3, 18'h0BCDE, 1'b1, 5'd9, 18'h1234);
        step(1'b1, 1'b0, 5'd0, 18'd0, 1'b1, 5'd9, 18'h1234);
        step(1'b1, 1'b0, 5'd0, 18'd0, 1'b1, 5'd9, 18'h1234);
        chk("drain_gnt", 32'(last_gnt), 32'd1);
        step(1'b1, 1'b0, 5'd0, 18'd0, 1'b0, 5'd0, 18'd0);
        chk("hold_release", 32'(hold), 32'd0);

        // Reach HOST, keep a stray writeback there, then reset with host_req high.
        for (int i = 0; i < STARVE_LIM + DRAIN_CYC + 1; i++) step(1'b1, 1'b1, 5'd12, 18'(i), 1'b1, 5'd20, 18'h2222);
        step(1'b0, 1'b0, 5'd0, 18'd0, 1'b1, 5'd20, 18'h2222);
        chk("rst_no_gnt", 32'(host_gnt), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5'd0, 18'd0, 1'b1, 5'd20, 18'h2222);

        // Randomized traffic with a host that holds its request until granted.
        pend = 1'b0; pa = '0; pd = '0;
        for (int i = 0; i < 3000; i++) begin
            wb_pct = ((i / 200) % 2 == 0) ? 40 : 95;
            r_r  = ($urandom_range(0, 599) != 0);
            r_we = ($urandom_range(0, 99) < wb_pct);
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend = 1'b1;
                pa   = 5'($urandom_range(0, 31));
                pd   = 18'($urandom);
            end else if (pend && $urandom_range(0, 299) == 0) begin
                pend = 1'b0;
            end
            step(r_r, r_we, 5'($urandom_range(0, 31)), 18'($urandom), pend, pa, pd);
            if (last_gnt) pend = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
